serial_addsub: RTL and testbench
================================

# serial_addsub

Bit-serial unsigned adder/subtractor for two WIDTH-bit operands. It sits directly upstream of the single-bit full adder/full subtractor cell logic: each cycle it presents one operand bit pair, LSB first, with the stored carry/borrow, and collects the resulting bit. The block trades latency for area and returns a WIDTH-bit result plus a carry-out/borrow-out flag through a start/busy/done handshake.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; sampled only when accepted (see Operation)
- mode  input  1  0 = add (a+b), 1 = subtract (a−b); latched on accept
- a  input  WIDTH  operand A, latched on accept
- b  input  WIDTH  operand B, latched on accept
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when result/cout are updated
- result  output  WIDTH  sum or difference, registered
- cout  output  1  add: carry out of MSB; subtract: final borrow (1 iff a<b)

## Operation
- States: IDLE, RUN, DONE.
- Internal registers: shift regs sa, sb (WIDTH), collect reg acc (WIDTH), cb flop (carry/borrow), bit counter cnt (ceil(log2(WIDTH)) bits, min 1), latched mode.
- IDLE/DONE + start=1: latch a→sa, b→sb, mode; cb←0; cnt←0; go RUN. Start accepted in DONE as in IDLE (back-to-back).
- start in RUN: ignored; operands/mode not re-latched.
- RUN, each edge: x=sa[0], y=sb[0], c=cb.
  - bit = x^y^c (both modes).
  - add: cb ← (x&y)|(y&c)|(c&x).
  - sub: cb ← (~x&y)|(y&c)|(c&~x).
  - acc ← {bit, acc[WIDTH-1:1]}; sa, sb shift right by 1; cnt ← cnt+1.
  - When cnt = WIDTH−1 on this edge: result ← final acc value (including this bit), cout ← new cb, go DONE.
- DONE: done=1 for exactly one cycle, then IDLE unless start accepted.
- result/cout only change at the RUN→DONE edge; they hold the previous completed value during RUN and indefinitely in IDLE.
- Arithmetic: add: {cout,result} = a+b exactly (WIDTH+1 bits). Sub: result = (a−b) mod 2^WIDTH, cout = borrow. Operands unsigned; no overflow flag.
- busy = (state==RUN); done = (state==DONE); both decoded from registered state.
- rst=1 at any edge (including mid-RUN): state←IDLE, busy=0, done=0, result=0, cout=0, sa=sb=acc=0, cb=0, cnt=0, mode=0. In-flight operation discarded; no done pulse. rst has priority over start.

## Timing
- Start accepted at edge k → busy=1 from edge k to edge k+WIDTH (WIDTH cycles).
- result/cout valid and done=1 in the cycle following edge k+WIDTH; latency start-accept to done = WIDTH+1 edges inclusive.
- Back-to-back: start=1 during the done cycle is accepted at edge k+WIDTH+1; busy high again next cycle; throughput one op per WIDTH+1 cycles.
- No combinational path from inputs to outputs.
- Reset values: busy=0, done=0, result=0, cout=0.

## Test plan
- Reset: hold rst 2 cycles with start=1 → busy=0, done=0, result=0x00, cout=0; no op starts.
- Add, WIDTH=8: a=0x12, b=0x34, mode=0 → busy exactly 8 cycles, done pulse 1 cycle, result=0x46, cout=0; a=0xA5, b=0x5B → result=0x00, cout=1.
- Subtract: a=0x05, b=0x07, mode=1 → result=0xFE, cout=1; a=0x80, b=0x01 → result=0x7F, cout=0; a=b=0xFF → result=0x00, cout=0.
- Start during busy: start add 0x01+0x01, pulse start with a=0xFF, b=0xFF, mode=1 at cycle 3 of RUN → result=0x02, cout=0, busy length unchanged, no second op.
- Reset mid-op: assert rst at cycle 4 of RUN after a previous result 0x46 → result=0x00, cout=0, no done pulse; next start completes normally.
- Back-to-back + random: start held during done cycle with new operands → second op accepted immediately, done spacing 9 cycles; 1000 random a/b/mode vs reference model a+b / a−b.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial unsigned adder/subtractor: one operand bit pair per cycle, LSB first,
// with a start/busy/done handshake and registered result/carry-out.
//
// state | meaning
// IDLE  | waiting for start, result/cout hold last value
// RUN   | shifting one bit pair per cycle through the full adder/subtractor
// DONE  | one-cycle done pulse; a new start is accepted here too
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc;
    logic             cb;
    logic [CW-1:0]    cnt;
    logic             mode_q;

    logic             x;
    logic             y;
    logic             sum_bit;
    logic             cb_next;
    logic [WIDTH-1:0] acc_next;

    // Subtraction uses the same cell with x inverted in the borrow term only.
    always_comb begin
        x        = sa[0];
        y        = sb[0];
        sum_bit  = x ^ y ^ cb;
        cb_next  = mode_q ? ((~x & y) | (y & cb) | (cb & ~x))
                          : ((x & y) | (y & cb) | (cb & x));
        acc_next = {sum_bit, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            acc    <= '0;
            cb     <= 1'b0;
            cnt    <= '0;
            mode_q <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sa     <= a;
                        sb     <= b;
                        mode_q <= mode;
                        cb     <= 1'b0;
                        cnt    <= '0;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cb  <= cb_next;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        result <= acc_next;
                        cout   <= cb_next;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed vector table, handshake corner
// sequences and randomized operations against an arithmetic reference model.
module tb_serial_addsub;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;

    int total = 0;
    int bad   = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vm;
        logic [W-1:0] er;
        logic         ec;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {borrow/carry, result} from plain integer arithmetic
    function automatic logic [W:0] model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                         input logic im);
        int unsigned ua, ub;
        ua = ia;
        ub = ib;
        if (!im) return (W+1)'(ua + ub);
        return {(ua < ub), W'(ua - ub)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic im,
                         output logic [W-1:0] r, output logic c, output int nb,
                         output logic d1, output logic d2);
        a = ia;
        b = ib;
        mode = im;
        start = 1'b1;
        tick();
        start = 1'b0;
        nb = 0;
        while (busy && nb < 64) begin
            nb++;
            tick();
        end
        d1 = done;
        r  = result;
        c  = cout;
        tick();
        d2 = done;
    endtask

    initial begin
        vec_t         vecs[7];
        logic [W-1:0] r;
        logic         c;
        int           nb;
        logic         d1, d2;
        logic [W:0]   m;
        int           n;
        int           dcount;

        vecs[0] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[1] = '{8'hA5, 8'h5B, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b1};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
        vecs[6] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b1};

        // reset held with start asserted
        rst = 1'b1;
        start = 1'b1;
        mode = 1'b0;
        a = 8'h12;
        b = 8'h34;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        rst = 1'b0;
        start = 1'b0;
        tick();
        check("rst_no_start", busy, 0);

        foreach (vecs[i]) begin
            do_op(vecs[i].va, vecs[i].vb, vecs[i].vm, r, c, nb, d1, d2);
            check($sformatf("vec%0d_result", i), r, vecs[i].er);
            check($sformatf("vec%0d_cout", i), c, vecs[i].ec);
            check($sformatf("vec%0d_busylen", i), nb, W);
            check($sformatf("vec%0d_done", i), d1, 1);
            check($sformatf("vec%0d_done_once", i), d2, 0);
        end

        // start pulsed during RUN must be ignored
        a = 8'h01;
        b = 8'h01;
        mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        nb = 0;
        while (busy && nb < 64) begin
            nb++;
            if (nb == 3) begin
                a = 8'hFF;
                b = 8'hFF;
                mode = 1'b1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check("ign_busylen", nb, W);
        check("ign_done", done, 1);
        check("ign_result", result, 8'h02);
        check("ign_cout", cout, 0);
        tick();
        check("ign_no_second", busy, 0);

        // reset in the middle of an operation
        do_op(8'h12, 8'h34, 1'b0, r, c, nb, d1, d2);
        check("pre_rst_result", r, 8'h46);
        a = 8'hFF;
        b = 8'h01;
        mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_result", result, 0);
        check("midrst_cout", cout, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        dcount = 0;
        for (int k = 0; k < 12; k++) begin
            if (done || busy) dcount++;
            tick();
        end
        check("midrst_quiet", dcount, 0);
        do_op(8'h33, 8'h22, 1'b1, r, c, nb, d1, d2);
        check("postrst_result", r, 8'h11);
        check("postrst_cout", c, 0);
        check("postrst_done", d1, 1);

        // back-to-back: start held through the done cycle
        a = 8'h10;
        b = 8'h20;
        mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 64) begin
            n++;
            tick();
        end
        check("b2b_first_done", done, 1);
        check("b2b_first_result", result, 8'h30);
        a = 8'h40;
        b = 8'h50;
        mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_busy_again", busy, 1);
        n = 1;
        while (!done && n < 64) begin
            n++;
            tick();
        end
        check("b2b_spacing", n, W + 1);
        check("b2b_second_result", result, 8'hF0);
        check("b2b_second_cout", cout, 1);
        tick();

        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra, rb;
            logic         rm;
            ra = W'($urandom);
            rb = W'($urandom);
            rm = 1'($urandom);
            m  = model(ra, rb, rm);
            do_op(ra, rb, rm, r, c, nb, d1, d2);
            check($sformatf("rnd%0d_result", i), r, m[W-1:0]);
            check($sformatf("rnd%0d_cout", i), c, m[W]);
            check($sformatf("rnd%0d_done", i), d1, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
